tl_lamp_monitor: RTL
====================

Name: tl_lamp_monitor

Overview:
- Downstream stage of the traffic-light controller; consumes its six aspect outputs (GRN1, YLW1, RED1, GRN2, YLW2, RED2).
- Registers the aspects and checks them for conflicting or illegal aspects and illegal sequences.
- Drives the physical lamp enables.
- On any fault, latches a fault code and forces fail-safe flashing red on both directions until an operator acknowledge.

Parameters:
STARTUP_CYC, 8, all-red cycles after reset and after fault recovery (>=1)
PERSIST, 2, consecutive cycles a per-direction aspect error must hold before it is a fault (>=1)
MIN_YLW, 3, minimum yellow cycles before red is legal (>=1)
FLASH_HALF, 4, cycles per flash half-period (>=1)
CW, 8, width of all internal counters; every other parameter must be < 2**CW

Ports:
CK  in  1  clock, rising edge
RN  in  1  asynchronous active-low reset
GRN1, YLW1, RED1  in  1 each  direction-1 aspects from controller
GRN2, YLW2, RED2  in  1 each  direction-2 aspects from controller
ACK  in  1  operator fault acknowledge, level
LAMP_G1, LAMP_Y1, LAMP_R1  out  1 each  direction-1 lamp enables
LAMP_G2, LAMP_Y2, LAMP_R2  out  1 each  direction-2 lamp enables
FAULT  out  1  high while in FAULT state
FAULT_CODE  out  3  first fault latched; 0 = none

Behaviour:
Reset (RN=0, asynchronous):
- Input sample registers are cleared to 0.
- All counters are cleared to 0.
- State goes to INIT.
- LAMP_R1=LAMP_R2=1, every other lamp 0, FAULT=0, FAULT_CODE=0.
Inputs and outputs:
- Every input, ACK included, is sampled into S_* registers every cycle.
- All checks use S_* and the S_* value from the previous cycle.
- Lamp outputs are registered.
States:
- INIT: lamps all-red; counter counts STARTUP_CYC cycles, then state goes to RUN. Checks are disabled.
- RUN: lamps follow the S_* values, so lamp latency from controller output is 2 cycles. Checks are enabled. Any detected fault goes to FAULT on the next edge and latches FAULT_CODE.
- FAULT: FAULT=1. LAMP_R1=LAMP_R2=flash, where flash starts at 1 on entry and toggles every FLASH_HALF cycles. All G/Y lamps are 0. When S_ACK=1 and S_RED1=S_RED2=1 are true in the same cycle, state goes to RECOVER.
- RECOVER: lamps all-red, FAULT=0, FAULT_CODE is held. After STARTUP_CYC cycles, FAULT_CODE clears and state goes to RUN. A new fault is not checked during RECOVER.
Fault codes, in priority order when several occur in the same cycle:
- 1 CONFLICT: (S_GRN1|S_YLW1) & (S_GRN2|S_YLW2). Immediate, no persistence filter.
- 2 ASPECT: in either direction, the count of asserted G/Y/R is not exactly 1, for PERSIST consecutive cycles. A per-direction counter resets whenever that direction is legal.
- 3 SHORT_YLW: a rising edge of red while the previous-cycle yellow run counter is < MIN_YLW.
  - The yellow run counter increments while yellow=1, saturates at 2**CW-1, and clears on a yellow falling edge plus one cycle.
  - The check applies only when yellow was 1 in the previous cycle.
- 4 SKIP_YLW: green in the previous cycle and red in the current cycle, with yellow 0 in both.
Further rules:
- Only the first fault is latched. Later faults while in FAULT are ignored.
- ACK held high continuously while entering FAULT does not skip FAULT; a full cycle in FAULT is required first.
- Asserting RN mid-FAULT clears FAULT_CODE and restarts INIT.
- All counters saturate; none wraps.

Decomposition:
- Package tl_pkg holds:
  - the state enum (INIT, RUN, FAULT, RECOVER);
  - FAULT_CODE localparams (F_NONE=0, F_CONFLICT=1, F_ASPECT=2, F_SHORT_YLW=3, F_SKIP_YLW=4);
  - the aspect bundle typedef {g, y, r}.
- One sub-module, tl_dir_checker, instantiated twice (one per direction). It:
  - holds the PERSIST counter and the yellow run counter;
  - outputs aspect_err, short_ylw, skip_ylw.
- Conflict detection, the state machine, the flasher and the lamp muxing live in the top module.

Test Plan:
- Reset then RN=1 with inputs R1=R2=1 -> lamps all-red for 8 cycles, then RUN; at cycle 9 with G1=1, R1=0, LAMP_G1 rises 2 cycles after the input.
- Legal sequence G1 (10 cycles) -> Y1 (3 cycles) -> R1 -> FAULT stays 0 and lamps mirror the inputs with 2-cycle delay.
- In RUN, drive G1=1 and G2=1 simultaneously for 1 cycle -> FAULT=1, FAULT_CODE=1, LAMP_R1/R2 toggling 1,1,1,1,0,0,0,0, G/Y lamps 0.
- Direction 1 dark (G/Y/R=0) for 1 cycle -> no fault; dark for 2 cycles -> FAULT_CODE=2. Y1 for 2 cycles then R1 -> FAULT_CODE=3. G1 directly to R1 -> FAULT_CODE=4.
- In FAULT, ACK=1 with R1=R2=1 -> RECOVER, 8 cycles all-red, FAULT_CODE=0, then RUN. ACK=1 with R2=0 -> stays in FAULT.
- Conflict and SKIP_YLW in the same cycle -> FAULT_CODE=1. A second fault while in FAULT leaves the code unchanged. RN pulse low during FAULT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light lamp monitor.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam logic [2:0] F_NONE      = 3'd0;
    localparam logic [2:0] F_CONFLICT  = 3'd1;
    localparam logic [2:0] F_ASPECT    = 3'd2;
    localparam logic [2:0] F_SHORT_YLW = 3'd3;
    localparam logic [2:0] F_SKIP_YLW  = 3'd4;

    typedef struct packed {
        logic g;
        logic y;
        logic r;
    } aspect_t;

    // Exactly one of G/Y/R lit is the only legal aspect for a direction.
    function automatic logic aspect_legal(aspect_t a);
        return (a == 3'b100) || (a == 3'b010) || (a == 3'b001);
    endfunction

endpackage

// File: rtl/tl_lamp_monitor_if.sv
// Controller-side aspects plus operator ACK in, lamp drives and fault status out.
interface tl_lamp_monitor_if;
    logic       GRN1, YLW1, RED1;
    logic       GRN2, YLW2, RED2;
    logic       ACK;
    logic       LAMP_G1, LAMP_Y1, LAMP_R1;
    logic       LAMP_G2, LAMP_Y2, LAMP_R2;
    logic       FAULT;
    logic [2:0] FAULT_CODE;

    // Controller / operator side
    modport master (
        output GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK,
        input  LAMP_G1, LAMP_Y1, LAMP_R1, LAMP_G2, LAMP_Y2, LAMP_R2, FAULT, FAULT_CODE
    );

    // Monitor side
    modport slave (
        input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK,
        output LAMP_G1, LAMP_Y1, LAMP_R1, LAMP_G2, LAMP_Y2, LAMP_R2, FAULT, FAULT_CODE
    );
endinterface

// File: rtl/tl_dir_checker.sv
// Per-direction aspect checks: persistent illegal aspect, short yellow, skipped yellow.
module tl_dir_checker
    import tl_pkg::*;
#(
    parameter int unsigned PERSIST = 2,
    parameter int unsigned MIN_YLW = 3,
    parameter int unsigned CW      = 8
) (
    input  logic    CK,
    input  logic    RN,
    input  aspect_t cur_i,
    input  aspect_t prev_i,
    output logic    aspect_err_o,
    output logic    short_ylw_o,
    output logic    skip_ylw_o
);

    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] ycnt_q, ycnt_d;
    logic          illegal;

    assign illegal = !aspect_legal(cur_i);

    // pcnt counts earlier consecutive illegal cycles; ycnt counts the yellow run
    // and only clears the cycle after yellow drops, so the red edge still sees it.
    always_comb begin
        pcnt_d = '0;
        ycnt_d = '0;
        if (illegal)
            pcnt_d = (pcnt_q == {CW{1'b1}}) ? pcnt_q : pcnt_q + 1'b1;
        if (cur_i.y)
            ycnt_d = (ycnt_q == {CW{1'b1}}) ? ycnt_q : ycnt_q + 1'b1;
    end

    // Counter state
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pcnt_q <= '0;
            ycnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            ycnt_q <= ycnt_d;
        end
    end

    assign aspect_err_o = illegal && (pcnt_q >= CW'(PERSIST - 1));
    assign short_ylw_o  = cur_i.r && !prev_i.r && prev_i.y && (ycnt_q < CW'(MIN_YLW));
    assign skip_ylw_o   = prev_i.g && cur_i.r && !prev_i.y && !cur_i.y;

endmodule

// File: rtl/tl_lamp_monitor.sv
// Lamp monitor: samples controller aspects, checks them, drives lamps, fail-safe flash on fault.
module tl_lamp_monitor
    import tl_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = 8,
    parameter int unsigned PERSIST     = 2,
    parameter int unsigned MIN_YLW     = 3,
    parameter int unsigned FLASH_HALF  = 4,
    parameter int unsigned CW          = 8
) (
    input logic              CK,
    input logic              RN,
    tl_lamp_monitor_if.slave bus
);

    aspect_t       s1_q, s2_q, p1_q, p2_q;
    logic          sack_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
    logic          flash_q, flash_d;
    logic [2:0]    code_q, code_d, fault_c;
    aspect_t       lamp1_q, lamp1_d, lamp2_q, lamp2_d;
    logic          aerr1, aerr2, short1, short2, skip1, skip2, conflict;

    // Sample every input each cycle and keep one cycle of history for edge checks
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            s1_q   <= '0;
            s2_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            sack_q <= 1'b0;
        end else begin
            s1_q   <= '{g: bus.GRN1, y: bus.YLW1, r: bus.RED1};
            s2_q   <= '{g: bus.GRN2, y: bus.YLW2, r: bus.RED2};
            p1_q   <= s1_q;
            p2_q   <= s2_q;
            sack_q <= bus.ACK;
        end
    end

    tl_dir_checker #(.PERSIST(PERSIST), .MIN_YLW(MIN_YLW), .CW(CW)) u_dir1 (
        .CK(CK), .RN(RN), .cur_i(s1_q), .prev_i(p1_q),
        .aspect_err_o(aerr1), .short_ylw_o(short1), .skip_ylw_o(skip1)
    );

    tl_dir_checker #(.PERSIST(PERSIST), .MIN_YLW(MIN_YLW), .CW(CW)) u_dir2 (
        .CK(CK), .RN(RN), .cur_i(s2_q), .prev_i(p2_q),
        .aspect_err_o(aerr2), .short_ylw_o(short2), .skip_ylw_o(skip2)
    );

    assign conflict = (s1_q.g | s1_q.y) & (s2_q.g | s2_q.y);

    // Highest-priority fault seen this cycle
    always_comb begin
        fault_c = F_NONE;
        if (conflict)                fault_c = F_CONFLICT;
        else if (aerr1 || aerr2)     fault_c = F_ASPECT;
        else if (short1 || short2)   fault_c = F_SHORT_YLW;
        else if (skip1 || skip2)     fault_c = F_SKIP_YLW;
    end

    // State machine, startup/recover counter, flasher and fault-code latch
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        code_d  = code_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q >= CW'(STARTUP_CYC - 1)) state_d = ST_RUN;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (fault_c != F_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fault_c;
                    flash_d = 1'b1;
                    fcnt_d  = '0;
                end
            end
            ST_FAULT: begin
                if (fcnt_q >= CW'(FLASH_HALF - 1)) begin
                    fcnt_d  = '0;
                    flash_d = ~flash_q;
                end else begin
                    fcnt_d  = fcnt_q + 1'b1;
                end
                if (sack_q && s1_q.r && s2_q.r) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (cnt_q >= CW'(STARTUP_CYC - 1)) begin
                    state_d = ST_RUN;
                    code_d  = F_NONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Lamp mux keyed on next state so lamps change on the same edge as the state
    always_comb begin
        lamp1_d = '{g: 1'b0, y: 1'b0, r: 1'b1};
        lamp2_d = '{g: 1'b0, y: 1'b0, r: 1'b1};
        case (state_d)
            ST_RUN: begin
                lamp1_d = s1_q;
                lamp2_d = s2_q;
            end
            ST_FAULT: begin
                lamp1_d = '{g: 1'b0, y: 1'b0, r: flash_d};
                lamp2_d = '{g: 1'b0, y: 1'b0, r: flash_d};
            end
            default: ;
        endcase
    end

    // Control and lamp registers
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            flash_q <= 1'b0;
            code_q  <= F_NONE;
            lamp1_q <= '{g: 1'b0, y: 1'b0, r: 1'b1};
            lamp2_q <= '{g: 1'b0, y: 1'b0, r: 1'b1};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
            code_q  <= code_d;
            lamp1_q <= lamp1_d;
            lamp2_q <= lamp2_d;
        end
    end

    assign bus.LAMP_G1    = lamp1_q.g;
    assign bus.LAMP_Y1    = lamp1_q.y;
    assign bus.LAMP_R1    = lamp1_q.r;
    assign bus.LAMP_G2    = lamp2_q.g;
    assign bus.LAMP_Y2    = lamp2_q.y;
    assign bus.LAMP_R2    = lamp2_q.r;
    assign bus.FAULT      = (state_q == ST_FAULT);
    assign bus.FAULT_CODE = code_q;

endmodule
